// File: rtl/unidade_controle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : unidade_controle_pkg
//  Purpose  : Shared types and constants for the control unit: FSM state
//             encoding, instruction class, field positions and special ops.
//  Revision : 1.0 - initial release
// ============================================================================
package unidade_controle_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } estado_t;

    // Instruction class derived from the op field
    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_NOP = 2'd1,
        CLS_CLR = 2'd2
    } classe_t;

    // Instruction field positions (low bit of each field)
    localparam int c_OP_W  = 5;
    localparam int c_OP_LO = 11;
    localparam int c_RC_LO = 9;
    localparam int c_RA_LO = 7;
    localparam int c_RB_LO = 5;

    // Special opcodes
    localparam logic [4:0] OP_NOP    = 5'b11110;
    localparam logic [4:0] OP_CLR    = 5'b11111;
    localparam logic [4:0] c_OP_ZERO = 5'b00000;

endpackage : unidade_controle_pkg
`default_nettype wire

// File: rtl/unidade_controle_decod.sv
`default_nettype none
// ============================================================================
//  Module   : unidade_controle_decod
//  Purpose  : Combinational instruction decoder. Splits a word into register
//             selects, ALU op and instruction class; NOP/CLR drive op = 0.
//  Revision : 1.0 - initial release
// ============================================================================
module unidade_controle_decod
    import unidade_controle_pkg::*;
#(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 2
) (
    input  logic [bits_palavra-1:0]  word,
    output logic [end_registros-1:0] sel_sa,
    output logic [end_registros-1:0] sel_sb,
    output logic [end_registros-1:0] sel_sc,
    output logic [c_OP_W-1:0]        op,
    output classe_t                  classe
);

    logic [c_OP_W-1:0] w_op_raw;
    logic              w_unused;

    assign w_op_raw = word[c_OP_LO +: c_OP_W];
    // Low bits of the word carry no information for this controller
    assign w_unused = ^word[c_RB_LO-1:0];

    // Field extraction and special-op classification
    always_comb begin
        sel_sa = word[c_RA_LO +: end_registros];
        sel_sb = word[c_RB_LO +: end_registros];
        sel_sc = word[c_RC_LO +: end_registros];
        op     = w_op_raw;
        classe = CLS_ALU;
        if (w_op_raw == OP_NOP) begin
            op     = c_OP_ZERO;
            classe = CLS_NOP;
        end else if (w_op_raw == OP_CLR) begin
            op     = c_OP_ZERO;
            classe = CLS_CLR;
        end
    end

endmodule : unidade_controle_decod
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module   : unidade_controle
//  Purpose  : Four-state instruction controller (IDLE/DECODE/EXECUTE/
//             WRITEBACK) driving a register bank and ALU with registered
//             selects, write enable, clear pulses and a retired-instr count.
//  Revision : 1.0 - initial release
// ============================================================================
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic [bits_palavra-1:0]  instr,
    output logic                     instr_ready,
    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [end_registros-1:0] Sel_SC,
    output logic [4:0]               controleOperacao,
    output logic                     reset_Ban_Registros,
    output logic                     reset_Flags,
    output logic                     busy,
    output logic [7:0]               instr_count
);

    estado_t                  r_state;
    logic [bits_palavra-1:0]  r_ir;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_hab;
    logic                     r_clr;
    logic [end_registros-1:0] r_sa;
    logic [end_registros-1:0] r_sb;
    logic [end_registros-1:0] r_sc;
    logic [4:0]               r_op;
    classe_t                  r_cls;
    logic [7:0]               r_count;

    logic                     w_accept;
    logic [bits_palavra-1:0]  w_word;
    logic [end_registros-1:0] w_sa;
    logic [end_registros-1:0] w_sb;
    logic [end_registros-1:0] w_sc;
    logic [4:0]               w_op;
    classe_t                  w_cls;

    // Decode the word being captured so selects are already valid in DECODE
    assign w_accept = r_ready & instr_valid;
    assign w_word   = w_accept ? instr : r_ir;

    unidade_controle_decod #(
        .bits_palavra  (bits_palavra),
        .end_registros (end_registros)
    ) u_decod (
        .word   (w_word),
        .sel_sa (w_sa),
        .sel_sb (w_sb),
        .sel_sc (w_sc),
        .op     (w_op),
        .classe (w_cls)
    );

    // Controller FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ir    <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_hab   <= 1'b0;
            r_clr   <= 1'b1;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sc    <= '0;
            r_op    <= '0;
            r_cls   <= CLS_ALU;
            r_count <= 8'd0;
        end else begin
            r_hab <= 1'b0;
            r_clr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ir    <= instr;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_sc    <= w_sc;
                        r_op    <= w_op;
                        r_cls   <= w_cls;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= DECODE;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DECODE: begin
                    // Clear pulse lands in the EXECUTE cycle only
                    r_clr   <= (r_cls == CLS_CLR);
                    r_state <= EXECUTE;
                end
                EXECUTE: begin
                    // Write enable lands in the WRITEBACK cycle only
                    r_hab   <= (r_cls == CLS_ALU);
                    r_state <= WRITEBACK;
                end
                WRITEBACK: begin
                    r_count <= r_count + 8'd1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready         = r_ready;
    assign busy                = r_busy;
    assign Hab_Escrita         = r_hab;
    assign reset_Ban_Registros = r_clr;
    assign reset_Flags         = r_clr;
    assign Sel_SA              = r_sa;
    assign Sel_SB              = r_sb;
    assign Sel_SC              = r_sc;
    assign controleOperacao    = r_op;
    assign instr_count         = r_count;

endmodule : unidade_controle
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unidade_controle
//  Purpose  : Directed self-checking bench for unidade_controle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        Hab_Escrita;
    logic [1:0]  Sel_SA;
    logic [1:0]  Sel_SB;
    logic [1:0]  Sel_SC;
    logic [4:0]  controleOperacao;
    logic        reset_Ban_Registros;
    logic        reset_Flags;
    logic        busy;
    logic [7:0]  instr_count;

    int checks   = 0;
    int failures = 0;

    unidade_controle #(
        .bits_palavra  (16),
        .end_registros (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .instr_valid         (instr_valid),
        .instr               (instr),
        .instr_ready         (instr_ready),
        .Hab_Escrita         (Hab_Escrita),
        .Sel_SA              (Sel_SA),
        .Sel_SB              (Sel_SB),
        .Sel_SC              (Sel_SC),
        .controleOperacao    (controleOperacao),
        .reset_Ban_Registros (reset_Ban_Registros),
        .reset_Flags         (reset_Flags),
        .busy                (busy),
        .instr_count         (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int accepts;
        logic [15:0] w;

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        step();
        step();

        // Reset state
        chk("rst_ready",   32'(instr_ready), 32'(0));
        chk("rst_busy",    32'(busy), 32'(0));
        chk("rst_hab",     32'(Hab_Escrita), 32'(0));
        chk("rst_sel",     32'({Sel_SA, Sel_SB, Sel_SC}), 32'(0));
        chk("rst_op",      32'(controleOperacao), 32'(0));
        chk("rst_count",   32'(instr_count), 32'(0));
        chk("rst_clr_ban", 32'(reset_Ban_Registros), 32'(1));
        chk("rst_clr_flg", 32'(reset_Flags), 32'(1));

        // Ordinary instruction 0A50
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h0A50;
        step();
        chk("alu_ready_post_rst", 32'(instr_ready), 32'(1));
        chk("alu_clr_off",        32'(reset_Ban_Registros), 32'(0));
        chk("alu_busy_idle",      32'(busy), 32'(0));
        step();                                    // DECODE
        instr_valid = 1'b0;
        chk("alu_dec_ready", 32'(instr_ready), 32'(0));
        chk("alu_dec_busy",  32'(busy), 32'(1));
        chk("alu_dec_sc",    32'(Sel_SC), 32'(2'b01));
        chk("alu_dec_sa",    32'(Sel_SA), 32'(2'b00));
        chk("alu_dec_sb",    32'(Sel_SB), 32'(2'b10));
        chk("alu_dec_op",    32'(controleOperacao), 32'(5'b00001));
        chk("alu_dec_hab",   32'(Hab_Escrita), 32'(0));
        step();                                    // EXECUTE
        chk("alu_ex_hab",    32'(Hab_Escrita), 32'(0));
        chk("alu_ex_op",     32'(controleOperacao), 32'(5'b00001));
        chk("alu_ex_sb",     32'(Sel_SB), 32'(2'b10));
        step();                                    // WRITEBACK
        chk("alu_wb_hab",    32'(Hab_Escrita), 32'(1));
        chk("alu_wb_clr",    32'(reset_Flags), 32'(0));
        chk("alu_wb_sc",     32'(Sel_SC), 32'(2'b01));
        step();                                    // IDLE
        chk("alu_idle_hab",   32'(Hab_Escrita), 32'(0));
        chk("alu_idle_count", 32'(instr_count), 32'(1));
        chk("alu_idle_ready", 32'(instr_ready), 32'(1));
        chk("alu_idle_busy",  32'(busy), 32'(0));

        // CLR instruction
        instr_valid = 1'b1;
        instr       = 16'hFFFF;
        step();                                    // DECODE
        instr_valid = 1'b0;
        chk("clr_dec_op",  32'(controleOperacao), 32'(0));
        chk("clr_dec_pls", 32'(reset_Ban_Registros), 32'(0));
        step();                                    // EXECUTE
        chk("clr_ex_ban",  32'(reset_Ban_Registros), 32'(1));
        chk("clr_ex_flg",  32'(reset_Flags), 32'(1));
        chk("clr_ex_hab",  32'(Hab_Escrita), 32'(0));
        step();                                    // WRITEBACK
        chk("clr_wb_ban",  32'(reset_Ban_Registros), 32'(0));
        chk("clr_wb_flg",  32'(reset_Flags), 32'(0));
        chk("clr_wb_hab",  32'(Hab_Escrita), 32'(0));
        step();                                    // IDLE
        chk("clr_count",   32'(instr_count), 32'(2));

        // NOP instruction
        instr_valid = 1'b1;
        instr       = 16'hF000;
        step();                                    // DECODE
        instr_valid = 1'b0;
        chk("nop_dec_op",  32'(controleOperacao), 32'(0));
        step();                                    // EXECUTE
        chk("nop_ex_pls",  32'({reset_Ban_Registros, reset_Flags}), 32'(0));
        chk("nop_ex_hab",  32'(Hab_Escrita), 32'(0));
        step();                                    // WRITEBACK
        chk("nop_wb_hab",  32'(Hab_Escrita), 32'(0));
        chk("nop_wb_pls",  32'({reset_Ban_Registros, reset_Flags}), 32'(0));
        chk("nop_wb_ready", 32'(instr_ready), 32'(0));
        step();                                    // IDLE, 4 cycles after accept
        chk("nop_count",   32'(instr_count), 32'(3));
        chk("nop_ready",   32'(instr_ready), 32'(1));

        // Valid held for 12 cycles with a new word every cycle
        accepts     = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w     = {5'(i + 1), 2'(i), 2'(i + 1), 2'(i + 2), 5'b0};
            instr = w;
            if (instr_ready) accepts++;
            if (i == 1 || i == 5 || i == 9) begin
                chk("stream_op", 32'(controleOperacao), 32'(5'(i)));
                chk("stream_sc", 32'(Sel_SC), 32'(2'(i - 1)));
            end
            step();
        end
        chk("stream_accepts", 32'(accepts), 32'(3));
        chk("stream_count",   32'(instr_count), 32'(6));
        chk("stream_ready",   32'(instr_ready), 32'(1));

        // Back-to-back ordinary instructions up to the counter wrap
        instr = 16'h0A50;
        repeat (4 * 249) step();
        chk("wrap_ff",       32'(instr_count), 32'(8'hFF));
        chk("wrap_ff_ready", 32'(instr_ready), 32'(1));
        repeat (4) step();
        chk("wrap_00",       32'(instr_count), 32'(8'h00));
        instr_valid = 1'b0;

        // Reset asserted during EXECUTE aborts the instruction
        step();                                    // settle in IDLE
        instr_valid = 1'b1;
        instr       = 16'h0A50;
        step();                                    // DECODE
        instr_valid = 1'b0;
        step();                                    // EXECUTE
        chk("abort_ex_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        step();
        chk("abort_busy",  32'(busy), 32'(0));
        chk("abort_hab",   32'(Hab_Escrita), 32'(0));
        chk("abort_ready", 32'(instr_ready), 32'(0));
        chk("abort_sel",   32'({Sel_SA, Sel_SB, Sel_SC}), 32'(0));
        chk("abort_op",    32'(controleOperacao), 32'(0));
        chk("abort_count", 32'(instr_count), 32'(0));
        chk("abort_clr",   32'({reset_Ban_Registros, reset_Flags}), 32'(2'b11));
        reset = 1'b1;
        step();
        chk("rel_ready", 32'(instr_ready), 32'(1));
        chk("rel_clr",   32'({reset_Ban_Registros, reset_Flags}), 32'(0));
        step();
        chk("rel_hab",   32'(Hab_Escrita), 32'(0));
        chk("rel_count", 32'(instr_count), 32'(0));
        chk("rel_busy",  32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_unidade_controle
`default_nettype wire
